// File: rtl/instr_word_encoder.sv
// instr_word_encoder: encodes decoded MIPS fields into 32-bit words and writes them through a 2-entry FIFO into instruction memory
module instr_word_encoder #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  mem_full,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err,
  output logic [7:0]            err_count
);
  localparam logic [ADDR_WIDTH+1:0] CAP = {2'b01, {ADDR_WIDTH{1'b0}}};
  logic [1:0]            fifoCount;
  logic [31:0]           headWord, tailWord, encWord;
  logic [ADDR_WIDTH+1:0] reserved;
  logic                  opOk, accept, push, pop, reject;
  // encode the field set and derive handshake/status; reserved counts written plus queued words
  always_comb begin
    opOk      = in_op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05};
    encWord   = in_op == 6'h00 ? {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct} : {in_op, in_rs, in_rt, in_imm};
    reserved  = {1'b0, word_count} + {{ADDR_WIDTH{1'b0}}, fifoCount};
    in_ready  = !start && fifoCount != 2'd2 && reserved < CAP;
    accept    = in_valid && in_ready;
    push      = accept && opOk;
    reject    = accept && !opOk;
    busy      = fifoCount != 2'd0;
    pop       = !start && busy && mem_ready;
    mem_we    = busy;
    mem_addr  = word_count[ADDR_WIDTH-1:0];
    mem_wdata = headWord;
    mem_full  = reserved == CAP;
  end
  // two-entry FIFO; a push that coincides with the pop of the last word lands directly at the head
  always_ff @(posedge clk or posedge reset) begin
    if (reset || start) begin
      fifoCount <= '0;
      headWord  <= '0;
      tailWord  <= '0;
    end else begin
      fifoCount <= fifoCount + {1'b0, push} - {1'b0, pop};
      headWord  <= push && (fifoCount == 2'd0 || pop) ? encWord : pop ? tailWord : headWord;
      tailWord  <= push && fifoCount == 2'd1 && !pop ? encWord : tailWord;
    end
  end
  // write count, registered error pulse and saturating error count
  always_ff @(posedge clk or posedge reset) begin
    if (reset || start) begin
      word_count <= '0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      word_count <= word_count + {{ADDR_WIDTH{1'b0}}, pop};
      err        <= reject;
      err_count  <= reject && err_count != 8'hFF ? err_count + 8'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: randomized and directed checks of instr_word_encoder against a queue-based model
module tb_instr_word_encoder;
  localparam int AW = 2;
  localparam int CAP = 1 << AW;
  logic clk = 0, reset = 1, start = 0, inValid = 0, memReady = 0;
  logic [5:0] inOp = 0, inFunct = 0;
  logic [4:0] inRs = 0, inRt = 0, inRd = 0, inShamt = 0;
  logic [15:0] inImm = 0;
  logic inReady, memWe, busy, memFull, err;
  logic [AW-1:0] memAddr;
  logic [31:0] memWdata;
  logic [AW:0] wordCount;
  logic [7:0] errCount;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  int wc = 0, ec = 0;
  bit merr = 0;

  instr_word_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_ready(inReady),
    .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
    .in_funct(inFunct), .in_imm(inImm), .mem_we(memWe), .mem_ready(memReady),
    .mem_addr(memAddr), .mem_wdata(memWdata), .busy(busy), .mem_full(memFull),
    .word_count(wordCount), .err(err), .err_count(errCount)
  );

  always #5 clk = ~clk;

  function automatic bit supported(input logic [5:0] op);
    return op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h04 || op == 6'h05;
  endfunction

  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                         input logic [5:0] fn, input logic [15:0] imm);
    longint v;
    v = ((longint'(op) * 32 + longint'(rs)) * 32 + longint'(rt)) * 65536;
    if (op == 6'h00) v += longint'(rd) * 2048 + longint'(sh) * 64 + longint'(fn);
    else v += longint'(imm);
    return v[31:0];
  endfunction

  function automatic bit modelReady();
    return !start && q.size() < 2 && wc + q.size() < CAP;
  endfunction

  function automatic logic [31:0] modelHead();
    return q.size() > 0 ? q[0] : 32'h0;
  endfunction

  task automatic setFields(input bit sup, input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                           input logic [5:0] fn, input logic [15:0] imm);
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05};
    if (sup) begin
      inOp = ops[$urandom_range(0, 5)];
      inRs = 5'($urandom); inRt = 5'($urandom); inRd = 5'($urandom);
      inShamt = 5'($urandom); inFunct = 6'($urandom); inImm = 16'($urandom);
    end else begin
      inOp = op; inRs = rs; inRt = rt; inRd = rd; inShamt = sh; inFunct = fn; inImm = imm;
    end
  endtask

  task automatic modelClear();
    q.delete(); wc = 0; ec = 0; merr = 0;
  endtask

  task automatic tick();
    bit acc, pp;
    if (start) modelClear();
    else begin
      acc = inValid && modelReady();
      pp = q.size() > 0 && memReady;
      if (pp) begin void'(q.pop_front()); wc++; end
      merr = acc && !supported(inOp);
      if (acc && supported(inOp)) q.push_back(encode(inOp, inRs, inRt, inRd, inShamt, inFunct, inImm));
      if (merr && ec < 255) ec++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    inValid = 0; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL reset_memWe got %0h want 0", memWe); end
    checks++; if (memAddr !== '0) begin errors++; $display("FAIL reset_memAddr got %0h want 0", memAddr); end
    checks++; if (memWdata !== 32'h0) begin errors++; $display("FAIL reset_memWdata got %0h want 0", memWdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (memFull !== 1'b0) begin errors++; $display("FAIL reset_memFull got %0h want 0", memFull); end
    checks++; if (wordCount !== '0) begin errors++; $display("FAIL reset_wordCount got %0d want 0", wordCount); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h want 0", err); end
    checks++; if (errCount !== 8'd0) begin errors++; $display("FAIL reset_errCount got %0d want 0", errCount); end
    @(posedge clk); #1;
    reset = 0;
    modelClear();
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %0h want 1", inReady); end
  endtask

  task automatic test_basic();
    logic [5:0] op [4], fn [4];
    logic [4:0] rs [4], rt [4], rd [4];
    logic [15:0] imm [4];
    logic [31:0] exp [4];
    op = '{6'h08, 6'h00, 6'h04, 6'h0D}; rs = '{5'd0, 5'd1, 5'd1, 5'd0}; rt = '{5'd8, 5'd2, 5'd2, 5'd9};
    rd = '{5'd0, 5'd3, 5'd0, 5'd0}; fn = '{6'h0, 6'h20, 6'h0, 6'h0}; imm = '{16'h0005, 16'h0, 16'hFFFF, 16'h00FF};
    exp = '{32'h20080005, 32'h00221820, 32'h1022FFFF, 32'h340900FF};
    memReady = 1;
    for (int k = 0; k < 5; k++) begin
      inValid = k < 4;
      if (k < 4) setFields(0, op[k], rs[k], rt[k], rd[k], 5'd0, fn[k], imm[k]);
      #1;
      if (k < 4) begin
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL basic_inReady%0d got %0h want 1", k, inReady); end
      end
      if (k > 0) begin
        checks++; if (memWe !== 1'b1) begin errors++; $display("FAIL basic_memWe%0d got %0h want 1", k, memWe); end
        checks++; if (memAddr !== AW'(k - 1)) begin errors++; $display("FAIL basic_addr%0d got %0d want %0d", k, memAddr, k - 1); end
        checks++; if (memWdata !== exp[k-1]) begin errors++; $display("FAIL basic_wdata%0d got %08h want %08h", k, memWdata, exp[k-1]); end
      end
      tick();
    end
    inValid = 0; #1;
    checks++; if (wordCount !== 3'd4) begin errors++; $display("FAIL basic_wordCount got %0d want 4", wordCount); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL basic_idle_memWe got %0h want 0", memWe); end
    checks++; if (memFull !== 1'b1) begin errors++; $display("FAIL basic_memFull got %0h want 1", memFull); end
  endtask

  task automatic test_reject();
    doStart();
    memReady = 1; inValid = 1;
    setFields(0, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0010);
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reject_inReady got %0h want 1", inReady); end
    tick();
    inValid = 0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL reject_err got %0h want 1", err); end
    checks++; if (errCount !== 8'd1) begin errors++; $display("FAIL reject_errCount got %0d want 1", errCount); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL reject_memWe got %0h want 0", memWe); end
    checks++; if (wordCount !== 3'd0) begin errors++; $display("FAIL reject_wordCount got %0d want 0", wordCount); end
    inValid = 1;
    setFields(0, 6'h0C, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234);
    tick();
    inValid = 0; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reject_errPulse got %0h want 0", err); end
    checks++; if (memWe !== 1'b1) begin errors++; $display("FAIL reject_andiWe got %0h want 1", memWe); end
    checks++; if (memAddr !== '0) begin errors++; $display("FAIL reject_andiAddr got %0d want 0", memAddr); end
    checks++; if (memWdata !== 32'h30431234) begin errors++; $display("FAIL reject_andiWdata got %08h want 30431234", memWdata); end
    tick();
    checks++; if (wordCount !== 3'd1) begin errors++; $display("FAIL reject_finalCount got %0d want 1", wordCount); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    int idx, writes;
    doStart();
    memReady = 0; idx = 0; writes = 0;
    inValid = 1; setFields(1, 0, 0, 0, 0, 0, 0, 0);
    w[0] = encode(inOp, inRs, inRt, inRd, inShamt, inFunct, inImm);
    for (int c = 0; c < 12; c++) begin
      if (c == 5) memReady = 1;
      #1;
      if (c < 5) begin
        checks++; if (inReady !== (idx < 2)) begin errors++; $display("FAIL bp_inReady%0d got %0h want %0h", c, inReady, idx < 2); end
        if (c > 0) begin
          checks++; if (memWdata !== w[0] || memWe !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got we=%0h %08h want we=1 %08h", c, memWe, memWdata, w[0]); end
        end
      end
      if (memWe && memReady) begin
        checks++; if (memAddr !== AW'(writes) || memWdata !== w[writes]) begin errors++; $display("FAIL bp_write%0d got %0d:%08h want %0d:%08h", writes, memAddr, memWdata, writes, w[writes]); end
        writes++;
      end
      if (inValid && modelReady()) begin
        tick();
        idx++;
        inValid = idx < 3;
        if (idx < 3) begin
          setFields(1, 0, 0, 0, 0, 0, 0, 0);
          w[idx] = encode(inOp, inRs, inRt, inRd, inShamt, inFunct, inImm);
        end
      end else tick();
    end
    checks++; if (writes !== 3) begin errors++; $display("FAIL bp_writes got %0d want 3", writes); end
    checks++; if (wordCount !== 3'd3) begin errors++; $display("FAIL bp_wordCount got %0d want 3", wordCount); end
  endtask

  task automatic test_capacity();
    int writes;
    doStart();
    memReady = 1; writes = 0;
    inValid = 1; setFields(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++; if (inReady !== modelReady()) begin errors++; $display("FAIL cap_inReady%0d got %0h want %0h", c, inReady, modelReady()); end
      checks++; if (memFull !== (wc + q.size() == CAP)) begin errors++; $display("FAIL cap_memFull%0d got %0h want %0h", c, memFull, wc + q.size() == CAP); end
      if (memWe) begin
        checks++; if (memAddr !== AW'(writes)) begin errors++; $display("FAIL cap_addr%0d got %0d want %0d", c, memAddr, writes); end
        writes++;
      end
      if (modelReady()) begin tick(); setFields(1, 0, 0, 0, 0, 0, 0, 0); end
      else tick();
    end
    #1;
    checks++; if (writes !== CAP) begin errors++; $display("FAIL cap_writes got %0d want %0d", writes, CAP); end
    checks++; if (wordCount !== 3'd4) begin errors++; $display("FAIL cap_wordCount got %0d want 4", wordCount); end
    checks++; if (memFull !== 1'b1 || inReady !== 1'b0) begin errors++; $display("FAIL cap_final got full=%0h ready=%0h want full=1 ready=0", memFull, inReady); end
    inValid = 0;
  endtask

  task automatic test_restart();
    doStart();
    memReady = 1; inValid = 1;
    setFields(0, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
    tick();
    memReady = 0;
    setFields(1, 0, 0, 0, 0, 0, 0, 0); tick();
    setFields(1, 0, 0, 0, 0, 0, 0, 0); tick();
    inValid = 1; start = 1; memReady = 1; #1;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL restart_inReady got %0h want 0", inReady); end
    tick();
    start = 0; memReady = 0; inValid = 0; #1;
    checks++; if (busy !== 1'b0 || memWe !== 1'b0) begin errors++; $display("FAIL restart_busy got busy=%0h we=%0h want 0", busy, memWe); end
    checks++; if (wordCount !== 3'd0 || errCount !== 8'd0) begin errors++; $display("FAIL restart_counts got wc=%0d ec=%0d want 0", wordCount, errCount); end
    memReady = 1; inValid = 1;
    setFields(0, 6'h23, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0); tick();
    setFields(1, 0, 0, 0, 0, 0, 0, 0); tick();
    setFields(1, 0, 0, 0, 0, 0, 0, 0); #1;
    #1 reset = 1;
    #1;
    checks++; if (memWe !== 1'b0 || busy !== 1'b0 || memWdata !== 32'h0 || memAddr !== '0) begin errors++; $display("FAIL areset_write got we=%0h busy=%0h %0d:%08h want 0", memWe, busy, memAddr, memWdata); end
    checks++; if (wordCount !== '0 || errCount !== 8'd0 || err !== 1'b0 || memFull !== 1'b0) begin errors++; $display("FAIL areset_status got wc=%0d ec=%0d err=%0h full=%0h want 0", wordCount, errCount, err, memFull); end
    reset = 0; inValid = 0;
    modelClear();
    tick();
    checks++; if (memWe !== 1'b0 || wordCount !== '0) begin errors++; $display("FAIL areset_after got we=%0h wc=%0d want 0", memWe, wordCount); end
  endtask

  task automatic test_random();
    doStart();
    for (int c = 0; c < 600; c++) begin
      start = $urandom_range(0, 14) == 0;
      inValid = $urandom_range(0, 3) != 0;
      memReady = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 4) == 0) setFields(0, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
      else setFields(1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (inReady !== modelReady()) begin errors++; $display("FAIL rnd_inReady%0d got %0h want %0h", c, inReady, modelReady()); end
      checks++; if (memWe !== (q.size() > 0) || busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd_busy%0d got we=%0h busy=%0h want %0h", c, memWe, busy, q.size() > 0); end
      checks++; if (memAddr !== AW'(wc % CAP) || wordCount !== (AW+1)'(wc)) begin errors++; $display("FAIL rnd_addr%0d got %0d/%0d want %0d/%0d", c, memAddr, wordCount, wc % CAP, wc); end
      if (q.size() > 0) begin
        checks++; if (memWdata !== modelHead()) begin errors++; $display("FAIL rnd_wdata%0d got %08h want %08h", c, memWdata, modelHead()); end
      end
      checks++; if (memFull !== (wc + q.size() == CAP)) begin errors++; $display("FAIL rnd_memFull%0d got %0h want %0h", c, memFull, wc + q.size() == CAP); end
      checks++; if (err !== merr || errCount !== 8'(ec)) begin errors++; $display("FAIL rnd_err%0d got %0h/%0d want %0h/%0d", c, err, errCount, merr, ec); end
      tick();
    end
    start = 0; inValid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_backpressure();
    test_capacity();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Converts a stream of decoded MIPS instruction fields (opcode, register numbers, shamt/funct, immediate) into 32-bit machine words and writes them sequentially into instruction memory. It performs the inverse of the opcode decoder in the single-cycle datapath: it accepts the same opcode set, rejects unsupported opcodes, and buffers encoded words in a 2-entry FIFO ahead of a stallable memory write port. The block sits in the program-loader path in front of the instruction ROM/RAM.

## Interface
- ADDR_WIDTH, 6, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  synchronous restart: flush FIFO, clear address and counters
- in_valid  in  1  field set on in_* is valid
- in_ready  out  1  block accepts the field set this cycle
- in_op  in  6  opcode
- in_rs, in_rt, in_rd  in  5 each  register numbers
- in_shamt  in  5  shift amount (R-type)
- in_funct  in  6  function code (R-type)
- in_imm  in  16  immediate / branch offset (I-type)
- mem_we  out  1  write request; mem_addr/mem_wdata valid while high
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_WIDTH  word address of current write
- mem_wdata  out  32  encoded instruction word
- busy  out  1  FIFO non-empty
- mem_full  out  1  all capacity reserved; no further accepts until start
- word_count  out  ADDR_WIDTH+1  words written to memory
- err  out  1  one-cycle pulse: rejected opcode accepted
- err_count  out  8  rejected opcodes, saturates at 255

## Operation
- Supported opcodes and formats:
  - 0x00 R-type: {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct}
  - 0x08 ADDI, 0x0C ANDI, 0x0D ORI, 0x04 BEQ, 0x05 BNE: {in_op, in_rs, in_rt, in_imm}
  - Any other opcode: rejected. Not written, consumes no capacity, pulses err, increments err_count.
- Accept handshake: transfer occurs on a rising edge with in_valid & in_ready. Fields are sampled only on that edge.
- in_ready = !start & (fifo_count < 2) & (reserved < 2^ADDR_WIDTH), where reserved = word_count + fifo_count.
- Rejected opcodes also need in_ready to be accepted. They are consumed even when mem_full = 1 only if in_ready is high, so with mem_full = 1 nothing is consumed.
- Write side: the FIFO head drives mem_wdata. mem_addr = word_count[ADDR_WIDTH-1:0], and mem_we = busy. A write completes on an edge with mem_we & mem_ready. That edge pops the FIFO and increments word_count.
- Simultaneous push and pop at fifo_count 1 leaves the count at 1, with the new word at the head on the next cycle. Push and pop at fifo_count 0 cannot occur.
- mem_full = (reserved == 2^ADDR_WIDTH). It stays high after draining, until start or reset.
- start has priority over every handshake in its cycle:
  - no push
  - no pop, even if mem_ready is high
  - no err
  - next state: FIFO empty, word_count = 0, err_count = 0
- Reset values: in_ready 1 after reset deasserts, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, mem_full 0, word_count 0, err 0, err_count 0. FIFO storage clears to 0.

## Timing
- Accept to mem_we: 1 cycle when the FIFO is empty. The word is registered on the accept edge and mem_we is high in the following cycle.
- Throughput: 1 word/cycle with mem_ready held high.
- mem_ready low holds mem_we, mem_addr and mem_wdata stable. Accepts continue until fifo_count = 2, then in_ready drops combinationally in the same cycle.
- err is registered: high for exactly the cycle after the rejecting accept edge.
- Reset asserted mid-transfer clears all state immediately, with no pending write completing. start mid-transfer does the same at the next edge.
- Wrap: mem_addr never wraps, because capacity reservation blocks accepts at 2^ADDR_WIDTH. The last write goes to address 2^ADDR_WIDTH-1 and word_count ends at 2^ADDR_WIDTH.

## Test plan
- Basic encoding, mem_ready = 1:
  - ADDI (op 0x08, rs 0, rt 8, imm 0x0005) -> mem_wdata 0x20080005 at addr 0
  - R-type add (op 0x00, rs 1, rt 2, rd 3, shamt 0, funct 0x20) -> 0x00221820 at addr 1
  - BEQ (op 0x04, rs 1, rt 2, imm 0xFFFF) -> 0x1022FFFF at addr 2
  - ORI (op 0x0D, rs 0, rt 9, imm 0x00FF) -> 0x340900FF at addr 3
  - Result: word_count = 4
- Reject: op 0x23 (lw) accepted -> err high for 1 cycle, err_count = 1, no mem_we, word_count unchanged. The next valid ANDI is written at the unchanged address.
- Backpressure: mem_ready = 0, 3 valid words presented -> first 2 accepted, in_ready low on the third and mem_wdata stable. Raise mem_ready -> words written in order at consecutive addresses, third accepted once a slot frees.
- Capacity, ADDR_WIDTH = 2: stream 6 valid words -> exactly 4 written at addresses 0..3, mem_full high after the 4th accept, in_ready stays 0, word_count = 4.
- Restart/reset: start with 2 words pending and mem_ready = 0 -> next cycle busy = 0, word_count = 0, err_count = 0, mem_we = 0. Async reset pulsed mid-stream between clock edges -> all outputs immediately at reset values.
